// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: samples AS/UDS/LDS, decodes RAM/VRAM/IO regions, inserts
// per-region wait states and answers each bus cycle with DTACKn or BERRn.
module m68k_bus_ctrl #(
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned VRAM_WAIT    = 1,
  parameter int unsigned IO_WAIT      = 2,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [23:1] cpu_a,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        ram_cs,
  output logic [1:0]  ram_we,
  output logic [13:0] ram_addr,
  input  logic [15:0] ram_dout,
  output logic        vram_wr,
  output logic        vram_rd,
  output logic [14:0] vram_addr,
  output logic [7:0]  vram_din,
  input  logic [7:0]  vram_dout,
  output logic        io_wr,
  output logic        io_rd,
  output logic [3:0]  io_addr,
  output logic [7:0]  io_din,
  input  logic [7:0]  io_dout
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERR} state_e;
  typedef enum logic [1:0] {R_RAM, R_VRAM, R_IO, R_NONE} region_e;

  localparam logic [7:0] RAM_LOAD  = 8'(RAM_WAIT);
  localparam logic [7:0] VRAM_LOAD = 8'(VRAM_WAIT);
  localparam logic [7:0] IO_LOAD   = 8'(IO_WAIT);
  localparam logic [7:0] BERR_LOAD = 8'(BERR_TIMEOUT - 2);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [23:1] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        uds_n_q, uds_n_d;
  logic        lds_n_q, lds_n_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        armed_q, armed_d;
  logic [15:0] cpu_din_q, cpu_din_d;
  logic [1:0]  ram_we_q, ram_we_d;
  logic        vram_wr_q, vram_wr_d;
  logic        vram_rd_q, vram_rd_d;
  logic        io_wr_q, io_wr_d;
  logic        io_rd_q, io_rd_d;

  region_e     region;
  logic [7:0]  wait_load;

  always_comb begin
    region    = R_NONE;
    wait_load = BERR_LOAD;
    if (addr_q[23:15] == '0) begin
      region    = R_RAM;
      wait_load = RAM_LOAD;
    end else if (addr_q[23:16] == 8'h10) begin
      region    = R_VRAM;
      wait_load = VRAM_LOAD;
    end else if (addr_q[23:16] == 8'hFF && addr_q[15:5] == '0) begin
      region    = R_IO;
      wait_load = IO_LOAD;
    end
  end

  // NOTE: every signal gets its default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    uds_n_d   = uds_n_q;
    lds_n_d   = lds_n_q;
    wdata_d   = wdata_q;
    armed_d   = armed_q;
    cpu_din_d = cpu_din_q;
    ram_we_d  = 2'b00;
    vram_wr_d = 1'b0;
    vram_rd_d = 1'b0;
    io_wr_d   = 1'b0;
    io_rd_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A new cycle starts only after AS has been seen high while idle.
        if (as_n) begin
          armed_d = 1'b1;
        end else if (armed_q && (!uds_n || !lds_n)) begin
          state_d = S_DECODE;
          armed_d = 1'b0;
          addr_d  = cpu_a;
          rw_d    = rw;
          uds_n_d = uds_n;
          lds_n_d = lds_n;
          wdata_d = cpu_dout[7:0];
        end
      end
      S_DECODE: begin
        if (as_n) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_WAIT;
          cnt_d     = wait_load;
          vram_rd_d = rw_q && (region == R_VRAM);
          io_rd_d   = rw_q && (region == R_IO);
        end
      end
      S_WAIT: begin
        if (as_n) begin
          state_d = S_IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (region == R_NONE) begin
          state_d   = S_ERR;
          cpu_din_d = 16'hFFFF;
        end else begin
          state_d = S_ACK;
          if (rw_q) begin
            unique case (region)
              R_RAM:   cpu_din_d = ram_dout;
              R_VRAM:  cpu_din_d = {8'hFF, vram_dout};
              default: cpu_din_d = {8'hFF, io_dout};
            endcase
          end else begin
            ram_we_d  = (region == R_RAM) ? {~uds_n_q, ~lds_n_q} : 2'b00;
            vram_wr_d = (region == R_VRAM) && !lds_n_q;
            io_wr_d   = (region == R_IO) && !lds_n_q;
          end
        end
      end
      S_ACK, S_ERR: begin
        if (as_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      uds_n_q   <= 1'b1;
      lds_n_q   <= 1'b1;
      wdata_q   <= '0;
      armed_q   <= 1'b0;
      cpu_din_q <= '0;
      ram_we_q  <= 2'b00;
      vram_wr_q <= 1'b0;
      vram_rd_q <= 1'b0;
      io_wr_q   <= 1'b0;
      io_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      uds_n_q   <= uds_n_d;
      lds_n_q   <= lds_n_d;
      wdata_q   <= wdata_d;
      armed_q   <= armed_d;
      cpu_din_q <= cpu_din_d;
      ram_we_q  <= ram_we_d;
      vram_wr_q <= vram_wr_d;
      vram_rd_q <= vram_rd_d;
      io_wr_q   <= io_wr_d;
      io_rd_q   <= io_rd_d;
    end
  end

  assign dtack_n   = (state_q != S_ACK);
  assign berr_n    = (state_q != S_ERR);
  assign ram_cs    = (state_q != S_IDLE) && (region == R_RAM);
  assign ram_addr  = addr_q[14:1];
  assign vram_addr = addr_q[15:1];
  assign io_addr   = addr_q[4:1];
  assign vram_din  = wdata_q;
  assign io_din    = wdata_q;
  assign cpu_din   = cpu_din_q;
  assign ram_we    = ram_we_q;
  assign vram_wr   = vram_wr_q;
  assign vram_rd   = vram_rd_q;
  assign io_wr     = io_wr_q;
  assign io_rd     = io_rd_q;

endmodule
